rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: WIDTH, default 64, bit width of each requester data word and of the output word.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  4  per-requester request; req[i] high means data_in_i is valid.
REQ-005 Port: data_in0, data_in1, data_in2, data_in3  input  WIDTH each  requester data words.
REQ-006 Port: gnt  output  4  one-hot acceptance strobe; gnt[i] high means data_in_i is captured at this clock edge.
REQ-007 Port: out_valid  output  1  output register holds an unconsumed word.
REQ-008 Port: out_data  output  WIDTH  captured word.
REQ-009 Port: out_src  output  2  index of the requester that supplied out_data.
REQ-010 Port: out_ready  input  1  consumer accepts out_data at this edge when out_valid is high.

Function
REQ-011 The block SHALL share one output channel among 4 requesters, using a round-robin 4:1 selection feeding a one-entry output register.
REQ-012 Output register state SHALL be EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-013 The signal can_load SHALL be defined as (!out_valid || out_ready); a load SHALL occur at an edge iff can_load && |req.
REQ-014 Selection SHALL be the first index i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4), where ptr is a 2-bit priority pointer.
REQ-015 gnt SHALL be combinational: gnt[sel]=1 iff a load occurs this cycle; gnt SHALL be all-zero otherwise and never have more than one bit set.
REQ-016 On a load: out_data<=data_in_sel, out_src<=sel, out_valid<=1, ptr<=sel+1 (mod 4, wrap 3->0).
REQ-017 If out_valid && out_ready && req==0: out_valid<=0 (FULL->EMPTY); out_data and out_src SHALL hold their values.
REQ-018 If out_valid && !out_ready: out_valid, out_data, out_src and ptr SHALL hold, and gnt SHALL be 0 regardless of req.
REQ-019 Simultaneous consume and load (FULL, out_ready=1, |req) SHALL replace the word in the same edge, sustaining 1 word/cycle.
REQ-020 Latency: a word granted at edge N SHALL appear on out_data with out_valid=1 immediately after edge N.
REQ-021 Fairness: a requester holding req continuously SHALL be granted within 4 loads.
REQ-022 Requesters hold req and data until they see gnt; the block SHALL NOT depend on req being dropped after gnt (back-to-back grants to one requester are legal when it is the only requester).
REQ-023 ptr SHALL change only on a load.

Reset
REQ-024 reset_n low SHALL asynchronously force out_valid=0, out_data=0, out_src=0, ptr=0; gnt SHALL read 0 while reset_n is low.
REQ-025 Reset asserted mid-operation SHALL discard any held word without presenting it; the first load after release SHALL use ptr=0.
REQ-026 Deassertion of reset_n SHALL take effect at the next rising clk edge; no load SHALL occur at an edge where reset_n is low.

Verification
REQ-027 Reset, then req=4'b0001, data_in0=0xA, out_ready=1 -> gnt=4'b0001 same cycle; next cycle out_valid=1, out_data=0xA, out_src=0, ptr=1.
REQ-028 req=4'b1111 held, out_ready=1, data_inK=K -> out_src sequence 0,1,2,3,0 on consecutive cycles; each gnt one-hot; wrap 3->0 shown.
REQ-029 FULL with out_src=2, out_ready=0 for 3 cycles, req=4'b1011 -> gnt=0, out_data and out_src stable; out_ready=1 -> gnt=4'b1000, next out_src=3.
REQ-030 Single requester req=4'b0100 held, out_ready=1 -> gnt[2]=1 every cycle; out_valid stays 1; ptr stays 3.
REQ-031 FULL, out_ready=1, req=0 -> out_valid=0 next cycle, out_data unchanged; following cycle with req=0, out_ready=0 -> no change.
REQ-032 FULL with ptr=2, assert reset_n=0 between edges -> out_valid=0 and gnt=0 immediately; after release with req=4'b1100 -> first grant index 2 (ptr=0 scan).

Source files
------------

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - round-robin 4:1 arbiter feeding a one-entry output register
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset_n    asynchronous active-low reset
//   req        per-requester request, req[i] qualifies data_in<i>
//   data_in0-3 requester data words
//   gnt        one-hot combinational acceptance strobe, data_in<i> captured this edge
//   out_valid  output register holds an unconsumed word
//   out_data   captured word
//   out_src    index of the requester that supplied out_data
//   out_ready  consumer accepts out_data at this edge when out_valid is high

module rr_arbiter4 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  output logic [3:0]       gnt,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  logic [1:0]       ptr;
  logic [1:0]       sel;
  logic [1:0]       idx;
  logic             found;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  // Scan ptr, ptr+1, ptr+2, ptr+3; the 2-bit sum wraps naturally.
  always_comb begin
    sel   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign can_load = !out_valid || out_ready;
  // reset_n gates the load so gnt reads zero while reset is held.
  assign load     = reset_n && can_load && found;

  always_comb begin
    gnt = 4'b0000;
    if (load) begin
      gnt[sel] = 1'b1;
    end
  end

  always_comb begin
    case (sel)
      2'd0:    sel_data = data_in0;
      2'd1:    sel_data = data_in1;
      2'd2:    sel_data = data_in2;
      default: sel_data = data_in3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      ptr       <= 2'd0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= sel;
      ptr       <= sel + 2'd1;
    end else if (out_valid && out_ready) begin
      // Consumed with nothing to replace it; data and source keep their values.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - directed self-checking bench for rr_arbiter4

module tb_rr_arbiter4;

  localparam int WIDTH = 64;

  logic             clk;
  logic             reset_n;
  logic [3:0]       req;
  logic [WIDTH-1:0] data_in0;
  logic [WIDTH-1:0] data_in1;
  logic [WIDTH-1:0] data_in2;
  logic [WIDTH-1:0] data_in3;
  logic [3:0]       gnt;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  int checks;
  int errors;

  rr_arbiter4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .data_in0  (data_in0),
    .data_in1  (data_in1),
    .data_in2  (data_in2),
    .data_in3  (data_in3),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data_index;
    data_in0 = 64'd0;
    data_in1 = 64'd1;
    data_in2 = 64'd2;
    data_in3 = 64'd3;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;
    set_data_index();
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d exp 0", out_src); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
  endtask

  task automatic test_single_grant;
    req      = 4'b0001;
    data_in0 = 64'hA;
    reset_n  = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL first_gnt got %b exp 0001", gnt); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 64'hA) begin errors++; $display("FAIL first_data got %h exp a", out_data); end
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL first_src got %0d exp 0", out_src); end
    // ptr is now 1, so with req=0011 requester 1 wins over 0.
    req = 4'b0011;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL first_ptr1 got %b exp 0010", gnt); end
  endtask

  task automatic test_rr_wrap;
    logic [3:0] exp_gnt;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    set_data_index();
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_gnt = 4'b0001 << (k % 4);
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, gnt, exp_gnt); end
      tick();
      checks++; if (out_src !== 2'(k % 4) || out_data !== 64'(k % 4) || out_valid !== 1'b1) begin
        errors++; $display("FAIL rr_out[%0d] got src %0d data %h valid %b exp src %0d", k, out_src, out_data, out_valid, k % 4);
      end
    end
  endtask

  task automatic test_backpressure;
    // ptr=1 here; load requester 2 to reach FULL with out_src=2, ptr=3.
    req = 4'b0100;
    tick();
    checks++; if (out_src !== 2'd2) begin errors++; $display("FAIL bp_setup_src got %0d exp 2", out_src); end
    out_ready = 1'b0;
    req       = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt[%0d] got %b exp 0000", k, gnt); end
      tick();
      checks++; if (out_src !== 2'd2 || out_data !== 64'd2 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] got src %0d data %h valid %b exp src 2 data 2 valid 1", k, out_src, out_data, out_valid);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL bp_release_gnt got %b exp 1000", gnt); end
    tick();
    checks++; if (out_src !== 2'd3) begin errors++; $display("FAIL bp_release_src got %0d exp 3", out_src); end
  endtask

  task automatic test_single_requester;
    // ptr=0; requester 2 alone is granted back to back and ptr stays 3.
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt[%0d] got %b exp 0100", k, gnt); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_src !== 2'd2) begin
        errors++; $display("FAIL single_out[%0d] got valid %b src %0d exp valid 1 src 2", k, out_valid, out_src);
      end
    end
    req = 4'b1001;
    #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL single_ptr3 got %b exp 1000", gnt); end
    tick();
  endtask

  task automatic test_drain;
    // FULL with src 3, data 3.
    req       = 4'b0000;
    out_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drain_gnt got %b exp 0000", gnt); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 64'd3 || out_src !== 2'd3) begin
      errors++; $display("FAIL drain_empty got valid %b data %h src %0d exp valid 0 data 3 src 3", out_valid, out_data, out_src);
    end
    out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 64'd3 || out_src !== 2'd3) begin
      errors++; $display("FAIL drain_idle got valid %b data %h src %0d exp valid 0 data 3 src 3", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_reset_mid;
    // ptr=0, EMPTY: load requester 1 so ptr=2 and FULL, then hold it.
    req = 4'b0010;
    tick();
    out_ready = 1'b0;
    req       = 4'b1100;
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin
      errors++; $display("FAIL mid_setup got valid %b src %0d exp valid 1 src 1", out_valid, out_src);
    end
    #2;
    out_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt got %b exp 0000", gnt); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_noload got %b exp 0", out_valid); end
    reset_n = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_first_gnt got %b exp 0100", gnt); end
    tick();
    checks++; if (out_src !== 2'd2 || out_data !== 64'd2) begin
      errors++; $display("FAIL mid_first_src got src %0d data %h exp src 2 data 2", out_src, out_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_grant();
    test_rr_wrap();
    test_backpressure();
    test_single_requester();
    test_drain();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
